// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry skid FIFO between ALU results and the register file, committing status flags on retire.
// Latency: an entry pushed into an empty FIFO is presented on wb_valid one cycle after the accepting edge.
// Backpressure: in_ready is registered (count<2) with no combinational path from wb_ready; blocked cycles are counted.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          upstream handshake
//   in_result, in_is_div       ALU result; divide results are sign-magnitude Q.8 with the sign at bit 15
//   in_cout/zero/overflow/neg  ALU flags for this result
//   in_rd, in_flags_we         destination register, commit flags when this entry retires
//   wb_valid/wb_ready          downstream handshake
//   wb_result, wb_rd           head entry data and destination
//   flags                      committed status {N,Z,C,V}
//   stall_cnt                  saturating count of cycles with in_valid=1 and in_ready=0
//
// Optional feature: define SM_TO_TC_EN to convert divide results to 32-bit two's complement on capture.

module alu_wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_is_div,
    input  logic        in_cout,
    input  logic        in_zero,
    input  logic        in_overflow,
    input  logic        in_neg,
    input  logic [3:0]  in_rd,
    input  logic        in_flags_we,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_result,
    output logic [3:0]  wb_rd,
    output logic [3:0]  flags,
    output logic [15:0] stall_cnt
);

    // Entry storage, indexed by the 1-bit head/tail pointers (wrap modulo 2).
    logic [31:0] res_q  [2];
    logic [3:0]  rd_q   [2];
    logic [3:0]  nzcv_q [2];
    logic        fwe_q  [2];

    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        rdy_en_q;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] stall_q, stall_d;

    logic        push;
    logic        pop;

    // Captured (normalised / converted) versions of the incoming entry.
    logic        neg_zero;
    logic [31:0] cap_res;
    logic [31:0] norm_res;
    logic        cap_n;
    logic        cap_z;

    // rdy_en_q holds in_ready low during reset and for the reset-release cycle,
    // so in_ready first rises on the first edge after rst_n deasserts.
    assign in_ready = rdy_en_q && (count_q < 2'd2);
    assign wb_valid = (count_q != 2'd0);
    assign push     = in_valid && in_ready;
    assign pop      = wb_valid && wb_ready;

    // Stale slots are masked so the outputs read zero whenever nothing is valid.
    assign wb_result = wb_valid ? res_q[head_q] : 32'd0;
    assign wb_rd     = wb_valid ? rd_q[head_q]  : 4'd0;
    assign flags     = flags_q;
    assign stall_cnt = stall_q;

    // A divide result of magnitude zero with the sign bit set is a negative zero:
    // clear the sign and report it as a plain zero.
    always_comb begin
        neg_zero = in_is_div && (in_result[14:0] == 15'd0);
        norm_res = in_result;
        if (neg_zero) begin
            norm_res[15] = 1'b0;
        end
        cap_n = neg_zero ? 1'b0 : in_neg;
        cap_z = neg_zero ? 1'b1 : in_zero;
        cap_res = norm_res;
`ifdef SM_TO_TC_EN
        if (in_is_div) begin
            if (norm_res[15]) begin
                cap_res = ~{17'd0, norm_res[14:0]} + 32'd1;
            end else begin
                cap_res = {17'd0, norm_res[14:0]};
            end
        end
`endif
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        flags_d = flags_q;
        stall_d = stall_q;

        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
            if (fwe_q[head_q]) begin
                flags_d = nzcv_q[head_q];
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
            rdy_en_q <= 1'b0;
            flags_q  <= 4'b0000;
            stall_q  <= 16'd0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
            flags_q  <= flags_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i]  <= 32'd0;
                rd_q[i]   <= 4'd0;
                nzcv_q[i] <= 4'd0;
                fwe_q[i]  <= 1'b0;
            end
        end else if (push) begin
            res_q[tail_q]  <= cap_res;
            rd_q[tail_q]   <= in_rd;
            nzcv_q[tail_q] <= {cap_n, cap_z, in_cout, in_overflow};
            fwe_q[tail_q]  <= in_flags_we;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: per-cycle vector table plus hand-written reset sequences.
// Each vector drives inputs, waits one rising edge, then samples outputs 1ns later.
// Expected values are hand-computed from the stage's behaviour.

module tb_alu_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_is_div;
    logic        in_cout;
    logic        in_zero;
    logic        in_overflow;
    logic        in_neg;
    logic [3:0]  in_rd;
    logic        in_flags_we;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_result;
    logic [3:0]  wb_rd;
    logic [3:0]  flags;
    logic [15:0] stall_cnt;

    int applied;
    int miscompares;

`ifdef SM_TO_TC_EN
    localparam logic [31:0] DIV8200 = 32'hFFFFFE00;
`else
    localparam logic [31:0] DIV8200 = 32'h00008200;
`endif

    typedef struct {
        logic        vld;
        logic [31:0] res;
        logic        div;
        logic [3:0]  nzcv;
        logic [3:0]  rd;
        logic        fwe;
        logic        wbr;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_res;
        logic [3:0]  e_rd;
        logic [3:0]  e_flags;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vt [25];

    alu_wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_is_div  (in_is_div),
        .in_cout    (in_cout),
        .in_zero    (in_zero),
        .in_overflow(in_overflow),
        .in_neg     (in_neg),
        .in_rd      (in_rd),
        .in_flags_we(in_flags_we),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_result  (wb_result),
        .wb_rd      (wb_rd),
        .flags      (flags),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic vld, input logic [31:0] res, input logic div,
                                input logic [3:0] nzcv, input logic [3:0] rd, input logic fwe,
                                input logic wbr, input logic e_rdy, input logic e_vld,
                                input logic [31:0] e_res, input logic [3:0] e_rd,
                                input logic [3:0] e_flags, input logic [15:0] e_stall);
        vec_t v;
        v.vld = vld; v.res = res; v.div = div; v.nzcv = nzcv; v.rd = rd; v.fwe = fwe; v.wbr = wbr;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_res = e_res; v.e_rd = e_rd;
        v.e_flags = e_flags; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s %s: got %h expected %h", tag, fld, act, exp);
            miscompares++;
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        applied++;
        chk(tag, "in_ready",  {31'd0, in_ready}, {31'd0, v.e_rdy});
        chk(tag, "wb_valid",  {31'd0, wb_valid}, {31'd0, v.e_vld});
        chk(tag, "wb_result", wb_result,         v.e_res);
        chk(tag, "wb_rd",     {28'd0, wb_rd},    {28'd0, v.e_rd});
        chk(tag, "flags",     {28'd0, flags},    {28'd0, v.e_flags});
        chk(tag, "stall_cnt", {16'd0, stall_cnt}, {16'd0, v.e_stall});
    endtask

    task automatic drive(input vec_t v);
        in_valid    = v.vld;
        in_result   = v.res;
        in_is_div   = v.div;
        in_neg      = v.nzcv[3];
        in_zero     = v.nzcv[2];
        in_cout     = v.nzcv[1];
        in_overflow = v.nzcv[0];
        in_rd       = v.rd;
        in_flags_we = v.fwe;
        wb_ready    = v.wbr;
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    initial begin
        vec_t idle_rst;
        applied     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        idle_rst    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle_rst);

        //         vld  result        div nzcv     rd  fwe wbr | rdy vld result        rd  flags    stall
        vt[0]  = mk(0, 32'h0,         0, 4'b0000, 0,  0,  1,   1,  0,  32'h0,        0,  4'b0000, 0);
        vt[1]  = mk(1, 32'h300,       0, 4'b0000, 3,  1,  1,   1,  1,  32'h300,      3,  4'b0000, 0);
        vt[2]  = mk(0, 32'h0,         0, 4'b0000, 0,  0,  1,   1,  0,  32'h0,        0,  4'b0000, 0);
        vt[3]  = mk(1, 32'h5,         0, 4'b0011, 5,  1,  1,   1,  1,  32'h5,        5,  4'b0000, 0);
        vt[4]  = mk(0, 32'h0,         0, 4'b0000, 0,  0,  1,   1,  0,  32'h0,        0,  4'b0011, 0);
        vt[5]  = mk(1, 32'h7,         0, 4'b1100, 6,  0,  1,   1,  1,  32'h7,        6,  4'b0011, 0);
        vt[6]  = mk(0, 32'h0,         0, 4'b0000, 0,  0,  1,   1,  0,  32'h0,        0,  4'b0011, 0);
        vt[7]  = mk(1, 32'h8000,      1, 4'b1000, 2,  1,  1,   1,  1,  32'h0,        2,  4'b0011, 0);
        vt[8]  = mk(0, 32'h0,         0, 4'b0000, 0,  0,  1,   1,  0,  32'h0,        0,  4'b0100, 0);
        vt[9]  = mk(1, 32'h8200,      1, 4'b1000, 9,  0,  1,   1,  1,  DIV8200,      9,  4'b0100, 0);
        vt[10] = mk(0, 32'h0,         0, 4'b0000, 0,  0,  1,   1,  0,  32'h0,        0,  4'b0100, 0);
        vt[11] = mk(1, 32'h8000,      0, 4'b1000, 1,  1,  1,   1,  1,  32'h8000,     1,  4'b0100, 0);
        vt[12] = mk(0, 32'h0,         0, 4'b0000, 0,  0,  1,   1,  0,  32'h0,        0,  4'b1000, 0);
        // Downstream stalled: fill, block, then drain in order.
        vt[13] = mk(1, 32'hA1,        0, 4'b0000, 10, 0,  0,   1,  1,  32'hA1,       10, 4'b1000, 0);
        vt[14] = mk(1, 32'hB2,        0, 4'b0000, 11, 0,  0,   0,  1,  32'hA1,       10, 4'b1000, 0);
        vt[15] = mk(1, 32'hC3,        0, 4'b0000, 12, 0,  0,   0,  1,  32'hA1,       10, 4'b1000, 1);
        vt[16] = mk(1, 32'hC3,        0, 4'b0000, 12, 0,  0,   0,  1,  32'hA1,       10, 4'b1000, 2);
        vt[17] = mk(1, 32'hC3,        0, 4'b0000, 12, 0,  1,   1,  1,  32'hB2,       11, 4'b1000, 3);
        vt[18] = mk(1, 32'hC3,        0, 4'b0000, 12, 0,  1,   1,  1,  32'hC3,       12, 4'b1000, 3);
        vt[19] = mk(0, 32'h0,         0, 4'b0000, 0,  0,  1,   1,  0,  32'h0,        0,  4'b1000, 3);
        // Count held at 1 with simultaneous push and pop.
        vt[20] = mk(1, 32'h100,       0, 4'b0010, 1,  1,  0,   1,  1,  32'h100,      1,  4'b1000, 3);
        vt[21] = mk(1, 32'h101,       0, 4'b0100, 2,  1,  1,   1,  1,  32'h101,      2,  4'b0010, 3);
        vt[22] = mk(1, 32'h102,       0, 4'b1000, 3,  1,  1,   1,  1,  32'h102,      3,  4'b0100, 3);
        vt[23] = mk(1, 32'h103,       0, 4'b0001, 4,  1,  1,   1,  1,  32'h103,      4,  4'b1000, 3);
        vt[24] = mk(1, 32'h104,       0, 4'b1000, 5,  0,  1,   1,  1,  32'h104,      5,  4'b0001, 3);

        // Reset state while rst_n is held low.
        #12;
        check_outputs("reset_hold", idle_rst);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            apply($sformatf("vec%0d", i), vt[i]);
        end

        // Asynchronous reset pulse with one entry buffered: outputs clear without a clock edge.
        in_valid = 1'b0;
        wb_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("mid_reset", idle_rst);
        #3;
        rst_n = 1'b1;

        // Buffered entry is gone, in_ready returns, flags stay cleared.
        apply("post_reset_idle", mk(0, 32'h0,  0, 4'b0000, 0, 0, 1, 1, 0, 32'h0,  0, 4'b0000, 0));
        apply("post_reset_push", mk(1, 32'h55, 0, 4'b0001, 7, 1, 1, 1, 1, 32'h55, 7, 4'b0000, 0));
        apply("post_reset_pop",  mk(0, 32'h0,  0, 4'b0000, 0, 0, 1, 1, 0, 32'h0,  0, 4'b0001, 0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
REQ-002 SHALL have upstream ports:
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_result  in  32  ALU result
- in_is_div  in  1  result comes from the divide unit (sign-magnitude Q.8, sign at bit 15)
- in_cout, in_zero, in_overflow, in_neg  in  1 each  ALU flags
- in_rd  in  4  destination register
- in_flags_we  in  1  update status flags on retire
REQ-003 SHALL have downstream ports:
- wb_valid  out  1  writeback entry valid
- wb_ready  in  1  register file accepts
- wb_result  out  32  writeback data
- wb_rd  out  4  destination register
- flags  out  4  committed status {N,Z,C,V}
- stall_cnt  out  16  cycles with in_valid=1 and in_ready=0

Function
REQ-004 SHALL buffer entries in a 2-deep FIFO (head/tail pointers, 2-bit count); upstream transfer when in_valid&in_ready; downstream transfer when wb_valid&wb_ready.
REQ-005 in_ready SHALL equal (count<2), registered state only; no combinational path from wb_ready to in_ready.
REQ-006 wb_valid SHALL equal (count>0); wb_result/wb_rd SHALL present the head entry and remain stable while wb_valid=1 and wb_ready=0.
REQ-007 Latency: an entry accepted into an empty FIFO at edge k SHALL appear on wb_valid after edge k (one cycle).
REQ-008 Simultaneous push and pop at count=1 SHALL keep count=1; at count=2 push is blocked (in_ready=0) while pop proceeds; at count=0 only push applies.
REQ-009 Head/tail pointers SHALL wrap modulo 2.
REQ-010 Negative-zero normalisation: for in_is_div=1 with in_result[14:0]=0, the captured result SHALL have bit 15 cleared and captured N forced to 0, Z forced to 1.
REQ-011 flags SHALL update at a downstream transfer whose entry has flags_we=1, with {N,Z,C,V}={neg,zero,cout,overflow} of that entry (after REQ-010); otherwise hold.
REQ-012 stall_cnt SHALL increment each cycle with in_valid=1 and in_ready=0, saturating at 16'hFFFF.
REQ-013 Entries with flags_we=0 SHALL retire without touching flags.

Reset
REQ-014 On rst_n=0, asynchronously: count=0, pointers=0, wb_valid=0, in_ready=0 while asserted, flags=4'b0000, stall_cnt=0, wb_result=0, wb_rd=0.
REQ-015 in_ready SHALL rise the first edge after rst_n deassertion; reset mid-transfer SHALL discard all buffered entries with no flag update.

Configuration
REQ-016 Macro SM_TO_TC_EN: when defined, div entries (after REQ-010) SHALL be converted on capture to 32-bit two's complement: magnitude {17'b0,bit[14:0]}, negated if bit 15 set; non-div entries unchanged.
REQ-017 Without SM_TO_TC_EN, div entries SHALL pass as captured (sign-magnitude, bits 31:16 zero) after REQ-010 only.

Verification
REQ-018 Reset then one push in_result=32'h00000300, in_rd=3, flags_we=1, zero=0, wb_ready=1 -> wb_valid=1 one cycle later, wb_result=32'h300, wb_rd=3, flags=4'b0000 after retire.
REQ-019 wb_ready=0, push three back-to-back entries -> in_ready=0 after second, stall_cnt=1 per blocked cycle, head stable; release wb_ready -> entries retire in order.
REQ-020 Div entry in_result=32'h00008000, neg=1, flags_we=1 -> wb_result=32'h0, flags=4'b0100.
REQ-021 With SM_TO_TC_EN, div entry 32'h00008200 -> wb_result=32'hFFFFFE00; without -> 32'h00008200.
REQ-022 count=1, simultaneous push and pop for 4 cycles -> count stays 1, no drop or duplicate; rst_n pulse mid-stream -> wb_valid=0, flags=0 immediately.
